// File: rtl/axi_burst_addr_gen.sv
// AXI master-side burst sequencer: accepts one burst command, checks its legality,
// then emits one address/strobe beat per downstream handshake.
module axi_burst_addr_gen #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [1:0]                cmd_burst,
   input  logic [2:0]                cmd_size,
   input  logic [7:0]                cmd_len,
   output logic                      cmd_err,
   output logic                      beat_valid,
   input  logic                      beat_ready,
   output logic [ADDR_WIDTH-1:0]     beat_addr,
   output logic [DATA_WIDTH/8-1:0]   beat_strb,
   output logic                      beat_last,
   output logic                      busy
);

   localparam int LANES    = DATA_WIDTH / 8;
   localparam int LANE_LOG = $clog2(LANES);
   localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(LANES - 1);

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [1:0] {IDLE, CHECK, ISSUE} state_t;

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   addr_reg;
   logic [1:0]              burst_reg;
   logic [2:0]              size_reg;
   logic [7:0]              len_reg;
   logic [7:0]              cnt_reg;

   logic [ADDR_WIDTH-1:0]   size_bytes, size_mask, aligned;
   logic [ADDR_WIDTH-1:0]   span, span_mask, last_byte;
   logic [ADDR_WIDTH-1:0]   incr_next, wrap_next, addr_next;
   logic [ADDR_WIDTH-1:0]   lane_lo, lane_hi;
   logic [LANES-1:0]        strb_raw;
   logic                    wrap_len_ok, crosses_4k, illegal, last_int;

   // All beat arithmetic works on registered command fields only.
   always_comb begin
      size_bytes  = ADDR_WIDTH'(1) << size_reg;
      size_mask   = size_bytes - ADDR_WIDTH'(1);
      aligned     = addr_reg & ~size_mask;
      span        = (ADDR_WIDTH'(len_reg) + ADDR_WIDTH'(1)) << size_reg;
      span_mask   = span - ADDR_WIDTH'(1);
      last_byte   = aligned + span_mask;
      crosses_4k  = last_byte[ADDR_WIDTH-1:12] != addr_reg[ADDR_WIDTH-1:12];
      wrap_len_ok = (len_reg == 8'd1) || (len_reg == 8'd3) ||
                    (len_reg == 8'd7) || (len_reg == 8'd15);
      incr_next   = aligned + size_bytes;
      // Wrap keeps the upper bits of the wrap window and lets the low bits roll over.
      wrap_next   = (addr_reg & ~span_mask) | (incr_next & span_mask);
      illegal     = (burst_reg == 2'b11) ||
                    (int'(size_reg) > LANE_LOG) ||
                    ((burst_reg == BURST_WRAP) &&
                     (!wrap_len_ok || ((addr_reg & size_mask) != '0))) ||
                    ((burst_reg == BURST_INCR) && crosses_4k);
      lane_lo     = addr_reg & LANE_MASK;
      lane_hi     = (aligned & LANE_MASK) + size_mask;
      last_int    = (cnt_reg == len_reg);
      addr_next   = addr_reg;
      case (burst_reg)
         BURST_INCR: addr_next = incr_next;
         BURST_WRAP: addr_next = wrap_next;
         default:    addr_next = addr_reg;
      endcase
   end

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [ADDR_WIDTH-1:0] LANE_IDX = ADDR_WIDTH'(gi);
      assign strb_raw[gi] = (LANE_IDX >= lane_lo) && (LANE_IDX <= lane_hi);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cmd_ready  = 1'b0;
      cmd_err    = 1'b0;
      beat_valid = 1'b0;
      busy       = 1'b1;
      case (state_reg)
         IDLE: begin
            busy      = 1'b0;
            cmd_ready = ~rst;
            if (cmd_valid) state_next = CHECK;
         end
         CHECK: begin
            if (illegal) begin
               cmd_err    = 1'b1;
               state_next = IDLE;
            end else begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            beat_valid = 1'b1;
            if (beat_ready && last_int) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_reg  <= '0;
         burst_reg <= '0;
         size_reg  <= '0;
         len_reg   <= '0;
         cnt_reg   <= '0;
      end else if (state_reg == IDLE && cmd_valid) begin
         addr_reg  <= cmd_addr;
         burst_reg <= cmd_burst;
         size_reg  <= cmd_size;
         len_reg   <= cmd_len;
         cnt_reg   <= '0;
      end else if (state_reg == ISSUE && beat_ready) begin
         addr_reg  <= addr_next;
         cnt_reg   <= cnt_reg + 8'd1;
      end
   end

   // Beat fields are forced low outside ISSUE so idle/reset outputs read as zero.
   assign beat_addr = beat_valid ? addr_reg : '0;
   assign beat_strb = beat_valid ? strb_raw : '0;
   assign beat_last = beat_valid & last_int;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Scoreboard bench for axi_burst_addr_gen: directed scenarios plus random commands,
// expected beats computed from burst rules with plain arithmetic.
module tb_axi_burst_addr_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_addr = '0;
   logic [1:0]  cmd_burst = '0;
   logic [2:0]  cmd_size = '0;
   logic [7:0]  cmd_len = '0;
   logic        cmd_err;
   logic        beat_valid;
   logic        beat_ready = 1'b0;
   logic [31:0] beat_addr;
   logic [3:0]  beat_strb;
   logic        beat_last;
   logic        busy;

   axi_burst_addr_gen #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_burst(cmd_burst), .cmd_size(cmd_size), .cmd_len(cmd_len), .cmd_err(cmd_err),
      .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
      .beat_strb(beat_strb), .beat_last(beat_last), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        err;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic        last;
   } exp_t;

   exp_t exp_q[$];
   int   chk_cnt = 0;
   int   pass_cnt = 0;
   int   hs_count = 0;
   int   rmode = 0;   // 0: always ready, 1: toggle, 2: random

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      chk_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0h required %0h", name, act, req);
   endtask

   // Reference model: legality and beat list derived directly from AXI burst rules.
   task automatic push_expected(input logic [31:0] addr, input logic [1:0] burst,
                                input logic [2:0] size, input logic [7:0] len);
      longint nb, al, total, base, a, lo, hi, lastb;
      bit bad;
      exp_t e;
      nb = 64'd1 << size;
      al = longint'(addr) - (longint'(addr) % nb);
      total = (longint'(len) + 1) * nb;
      bad = 0;
      if (burst == 2'b11) bad = 1;
      if (nb > 4) bad = 1;
      if (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) bad = 1;
      if (burst == 2'b10 && (longint'(addr) % nb) != 0) bad = 1;
      if (burst == 2'b01) begin
         lastb = al + total - 1;
         if ((lastb >> 12) != (longint'(addr) >> 12)) bad = 1;
      end
      if (bad) begin
         e = '0;
         e.err = 1'b1;
         exp_q.push_back(e);
         $display("cmd addr=%08h burst=%0d size=%0d len=%0d -> error", addr, burst, size, len);
         return;
      end
      base = longint'(addr) - (longint'(addr) % total);
      for (int n = 0; n <= int'(len); n++) begin
         if (burst == 2'b00 || n == 0) a = longint'(addr);
         else if (burst == 2'b01) a = al + longint'(n) * nb;
         else a = base + ((longint'(addr) - base + longint'(n) * nb) % total);
         a = a & 64'hFFFF_FFFF;
         lo = a % 4;
         hi = ((a - (a % nb)) % 4) + nb - 1;
         e.err  = 1'b0;
         e.addr = a[31:0];
         for (int i = 0; i < 4; i++) e.strb[i] = (i >= lo) && (i <= hi);
         e.last = (n == int'(len));
         exp_q.push_back(e);
      end
      $display("cmd addr=%08h burst=%0d size=%0d len=%0d -> %0d beats", addr, burst, size, len, int'(len) + 1);
   endtask

   always @(posedge clk) begin
      #1;
      case (rmode)
         0: beat_ready = 1'b1;
         1: beat_ready = ~beat_ready;
         default: beat_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Monitor: pops the scoreboard on every beat handshake or error pulse.
   logic        hold_pending = 1'b0;
   logic [36:0] hold_val;
   exp_t        got;
   always @(negedge clk) begin
      if (rst) begin
         hold_pending = 1'b0;
      end else begin
         if (hold_pending) check("hold_stable", {beat_addr, beat_strb, beat_last}, hold_val);
         hold_pending = 1'b0;
         if (beat_valid) check("busy_during_beat", busy, 1'b1);
         check("ready_vs_busy", cmd_ready, !busy);
         if (beat_valid && !beat_ready) begin
            hold_pending = 1'b1;
            hold_val = {beat_addr, beat_strb, beat_last};
         end
         if (cmd_err) begin
            if (exp_q.size() == 0) check("unexpected_err", 1'b1, 1'b0);
            else begin
               got = exp_q.pop_front();
               check("err_expected", 1'b1, got.err);
            end
         end
         if (beat_valid && beat_ready) begin
            hs_count++;
            if (exp_q.size() == 0) check("unexpected_beat", 1'b1, 1'b0);
            else begin
               got = exp_q.pop_front();
               check("beat_is_not_err", 1'b0, got.err);
               check("beat_addr", beat_addr, got.addr);
               check("beat_strb", beat_strb, got.strb);
               check("beat_last", beat_last, got.last);
               $display("beat addr=%08h strb=%h last=%0d", beat_addr, beat_strb, beat_last);
            end
         end
      end
   end

   task automatic issue_cmd(input logic [31:0] addr, input logic [1:0] burst,
                            input logic [2:0] size, input logic [7:0] len);
      int t = 0;
      @(posedge clk); #1;
      while (!cmd_ready && t < 2000) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 2000) check("cmd_ready_timeout", 1'b0, 1'b1);
      push_expected(addr, burst, size, len);
      cmd_valid = 1'b1;
      cmd_addr  = addr;
      cmd_burst = burst;
      cmd_size  = size;
      cmd_len   = len;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      @(negedge clk);
      while ((busy || exp_q.size() != 0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) check("burst_timeout", 1'b0, 1'b1);
   endtask

   task automatic send_cmd(input logic [31:0] addr, input logic [1:0] burst,
                           input logic [2:0] size, input logic [7:0] len);
      bit err;
      issue_cmd(addr, burst, size, len);
      err = (exp_q.size() != 0) && exp_q[exp_q.size() - 1].err;
      @(negedge clk);
      check("check_cycle_no_beat", beat_valid, 1'b0);
      check("check_cycle_err", cmd_err, err);
      @(negedge clk);
      check("first_beat_latency", beat_valid, !err);
      if (err) check("ready_after_err", cmd_ready, 1'b1);
      wait_done();
   endtask

   initial begin
      int base;
      int t;
      logic [31:0] ra;
      logic [1:0]  rb;
      logic [2:0]  rs;
      logic [7:0]  rl;
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_outputs", {beat_valid, beat_addr, beat_strb, beat_last, cmd_err, busy}, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", cmd_ready, 1'b1);

      rmode = 0;
      send_cmd(32'h1000, 2'b01, 3'd2, 8'd3);
      send_cmd(32'h1038, 2'b10, 3'd2, 8'd3);
      send_cmd(32'h2001, 2'b01, 3'd2, 8'd1);
      send_cmd(32'h0FF8, 2'b01, 3'd2, 8'd3);
      send_cmd(32'h1000, 2'b10, 3'd2, 8'd2);
      send_cmd(32'h1000, 2'b01, 3'd3, 8'd0);
      send_cmd(32'h1000, 2'b11, 3'd0, 8'd0);
      send_cmd(32'h0FFC, 2'b01, 3'd2, 8'd0);
      send_cmd(32'h0FFF, 2'b00, 3'd0, 8'd5);
      send_cmd(32'h0103, 2'b00, 3'd1, 8'd2);

      rmode = 1;
      send_cmd(32'h1000, 2'b01, 3'd2, 8'd3);
      send_cmd(32'h1006, 2'b10, 3'd1, 8'd7);

      rmode = 0;
      base = hs_count;
      issue_cmd(32'h3000, 2'b01, 3'd2, 8'd7);
      t = 0;
      while (hs_count < base + 2 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) check("abort_wait_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("abort_outputs_zero",
            {cmd_ready, beat_valid, beat_addr, beat_strb, beat_last, cmd_err, busy}, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_abort", cmd_ready, 1'b1);
      send_cmd(32'h40, 2'b00, 3'd0, 8'd2);

      rmode = 2;
      for (int k = 0; k < 120; k++) begin
         ra = $urandom;
         rb = 2'($urandom_range(0, 3));
         rs = 3'($urandom_range(0, 3));
         rl = 8'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) ra = ra & ~((32'd1 << rs) - 32'd1);
         if (rb == 2'b10 && $urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 3))
               0: rl = 8'd1;
               1: rl = 8'd3;
               2: rl = 8'd7;
               default: rl = 8'd15;
            endcase
         end
         send_cmd(ra, rb, rs, rl);
      end

      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
